pattern_lock_detector: RTL and testbench
========================================

# pattern_lock_detector

Parametrised successor to the fixed 3-bit sequence validator: a programmable, maskable pattern detector with a lock state machine. Qualifies a word stream against a runtime pattern, declares lock after LOCK_COUNT consecutive enabled matches, and tolerates up to UNLOCK_COUNT-1 consecutive misses before dropping lock. Sits between the framing/deserialiser front end and downstream consumers gated by valid_flag.

## Interface
- SEQUENCE_WIDTH, 3, width of compared word
- LOCK_COUNT, 2, consecutive enabled matches required to lock (≥1)
- UNLOCK_COUNT, 2, consecutive enabled misses that drop lock (≥1)
- CNT_WIDTH, 4, counter width; LOCK_COUNT and UNLOCK_COUNT < 2**CNT_WIDTH
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- enable  input  1  qualifies sequence; low = hold all state
- clear  input  1  synchronous return to SEARCH, priority over enable
- sequence  input  SEQUENCE_WIDTH  word under test
- pattern  input  SEQUENCE_WIDTH  target word
- mask  input  SEQUENCE_WIDTH  per-bit compare enable (PATTERN_MASK_EN only)
- valid_flag  output  1  registered; high in LOCKED or FLYWHEEL
- lock_lost  output  1  one-cycle registered pulse on lock drop
- match_count  output  CNT_WIDTH  current consecutive-match run, saturating
- state  output  2  SEARCH=0, VERIFY=1, LOCKED=2, FLYWHEEL=3

## Operation
- match = ((sequence ^ pattern) & mask) == 0; evaluated only when enable=1.
- SEARCH: match → VERIFY (LOCKED if LOCK_COUNT==1); miss → stay.
- VERIFY: match → run+1, LOCKED when run reaches LOCK_COUNT; miss → SEARCH.
- LOCKED: match → stay; miss → FLYWHEEL, miss count=1 (UNLOCK_COUNT==1: straight to SEARCH).
- FLYWHEEL: match → LOCKED, miss count=0; miss → miss count+1, SEARCH at UNLOCK_COUNT with lock_lost pulse.
- match_count: +1 per enabled match, saturates at 2**CNT_WIDTH-1, zeroed on enabled miss, clear, reset.
- enable=0: state, counters, valid_flag frozen; lock_lost still deasserts next cycle.
- clear=1: SEARCH, counters 0, valid_flag 0, no lock_lost pulse, regardless of enable.
- pattern/mask changes take effect on the next compare; no automatic relock.

## Timing
- Reset (async assert, sync-to-clk deassert external): state=SEARCH, valid_flag=0, lock_lost=0, match_count=0, internal counters 0.
- Default parameters: matches sampled at edges N and N+1 → valid_flag high after edge N+1 (one cycle after second match presented).
- Lock drop: UNLOCK_COUNT-th consecutive miss sampled at edge M → after M valid_flag=0, lock_lost=1 for exactly one cycle.
- All outputs registered; no combinational path input→output.
- Reset mid-operation: immediate return to reset values; lock_lost never asserted by reset.

## Configuration
- PATTERN_MASK_EN defined: mask port present and applied per bit.
- Undefined: mask port absent; compare is full-width equality (mask treated as all ones).

## Structure
- Package pattern_lock_pkg: state encoding localparams/typedef (SEARCH, VERIFY, LOCKED, FLYWHEEL), state width constant.
- Sub-module pattern_lock_compare: combinational masked compare producing match; FSM and counters in top.

## Test plan
- Reset defaults: pattern=3'b101, sequence=3'b101, enable=1; hold resetn=0 → valid_flag=0, state=0, match_count=0.
- Basic lock: two enabled 3'b101 words → valid_flag=1 after second edge, match_count=2, state=2.
- Flywheel: locked, one 3'b100 then 3'b101 → state 3 then 2, valid_flag stays 1, no lock_lost.
- Lock loss: locked, two consecutive 3'b000 → valid_flag=0, lock_lost=1 exactly one cycle, state=0.
- Enable gating/clear: in VERIFY drop enable 5 cycles with mismatching sequence → state/match_count unchanged; assert clear → state=0, match_count=0.
- Mask (PATTERN_MASK_EN): mask=3'b101, pattern=3'b101, sequence=3'b111 twice → lock; LOCK_COUNT=4, UNLOCK_COUNT=1 variant locks on 4th match, drops on first miss.

Source files
------------

// File: rtl/pattern_lock_pkg.sv
// Shared state encoding for the pattern lock detector.
// The optional per-bit compare mask is enabled with the PATTERN_MASK_EN macro.
package pattern_lock_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_SEARCH   = 2'd0,
        ST_VERIFY   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FLYWHEEL = 2'd3
    } lock_state_t;

endpackage

// File: rtl/pattern_lock_compare.sv
// Combinational masked word compare: match when every enabled bit agrees.
// Built once per bit so a cleared mask bit fully removes that lane from the compare.
module pattern_lock_compare #(
    parameter int SEQUENCE_WIDTH = 3
) (
    input  logic [SEQUENCE_WIDTH-1:0] sequence_word,
    input  logic [SEQUENCE_WIDTH-1:0] pattern,
    input  logic [SEQUENCE_WIDTH-1:0] mask,
    output logic                      match
);

    logic [SEQUENCE_WIDTH-1:0] bit_miss;

    generate
        for (genvar gi = 0; gi < SEQUENCE_WIDTH; gi++) begin : g_lane
            assign bit_miss[gi] = (sequence_word[gi] ^ pattern[gi]) & mask[gi];
        end
    endgenerate

    assign match = ~|bit_miss;

endmodule

// File: rtl/pattern_lock_detector.sv
// Programmable pattern detector with SEARCH/VERIFY/LOCKED/FLYWHEEL lock FSM.
// Define PATTERN_MASK_EN to expose the per-bit mask port; otherwise full-width equality.
module pattern_lock_detector
    import pattern_lock_pkg::*;
#(
    parameter int SEQUENCE_WIDTH = 3,
    parameter int LOCK_COUNT     = 2,
    parameter int UNLOCK_COUNT   = 2,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic                      clear,
    // "sequence" is a reserved word, hence the suffix
    input  logic [SEQUENCE_WIDTH-1:0] sequence_word,
    input  logic [SEQUENCE_WIDTH-1:0] pattern,
`ifdef PATTERN_MASK_EN
    input  logic [SEQUENCE_WIDTH-1:0] mask,
`endif
    output logic                      valid_flag,
    output logic                      lock_lost,
    output logic [CNT_WIDTH-1:0]      match_count,
    output logic [STATE_W-1:0]        state
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LOCK_CNT_C   = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_CNT_C = CNT_WIDTH'(UNLOCK_COUNT);

    lock_state_t                state_reg;
    logic                       valid_reg;
    logic                       lost_reg;
    logic [CNT_WIDTH-1:0]       match_cnt_reg;
    logic [CNT_WIDTH-1:0]       miss_cnt_reg;

    logic [SEQUENCE_WIDTH-1:0]  mask_eff;
    logic                       match;
    logic [CNT_WIDTH-1:0]       match_cnt_next;
    logic [CNT_WIDTH-1:0]       miss_cnt_next;

`ifdef PATTERN_MASK_EN
    assign mask_eff = mask;
`else
    assign mask_eff = '1;
`endif

    pattern_lock_compare #(
        .SEQUENCE_WIDTH (SEQUENCE_WIDTH)
    ) u_compare (
        .sequence_word (sequence_word),
        .pattern       (pattern),
        .mask          (mask_eff),
        .match         (match)
    );

    // Saturating increments used by the FSM below
    assign match_cnt_next = (match_cnt_reg == CNT_MAX) ? CNT_MAX : match_cnt_reg + CNT_ONE;
    assign miss_cnt_next  = (miss_cnt_reg  == CNT_MAX) ? CNT_MAX : miss_cnt_reg  + CNT_ONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_SEARCH;
            valid_reg     <= 1'b0;
            lost_reg      <= 1'b0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            lost_reg <= 1'b0;
            if (clear) begin
                state_reg     <= ST_SEARCH;
                valid_reg     <= 1'b0;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
            end else if (enable) begin
                match_cnt_reg <= match ? match_cnt_next : '0;
                case (state_reg)
                    ST_SEARCH: begin
                        if (match) begin
                            if (LOCK_COUNT == 1) begin
                                state_reg <= ST_LOCKED;
                                valid_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (!match) begin
                            state_reg <= ST_SEARCH;
                        end else if (match_cnt_next >= LOCK_CNT_C) begin
                            state_reg <= ST_LOCKED;
                            valid_reg <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            if (UNLOCK_COUNT == 1) begin
                                state_reg <= ST_SEARCH;
                                valid_reg <= 1'b0;
                                lost_reg  <= 1'b1;
                            end else begin
                                state_reg    <= ST_FLYWHEEL;
                                miss_cnt_reg <= CNT_ONE;
                            end
                        end
                    end
                    ST_FLYWHEEL: begin
                        if (match) begin
                            state_reg    <= ST_LOCKED;
                            miss_cnt_reg <= '0;
                        end else if (miss_cnt_next >= UNLOCK_CNT_C) begin
                            state_reg    <= ST_SEARCH;
                            valid_reg    <= 1'b0;
                            lost_reg     <= 1'b1;
                            miss_cnt_reg <= '0;
                        end else begin
                            miss_cnt_reg <= miss_cnt_next;
                        end
                    end
                    default: begin
                        state_reg    <= ST_SEARCH;
                        valid_reg    <= 1'b0;
                        miss_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign valid_flag  = valid_reg;
    assign lock_lost   = lost_reg;
    assign match_count = match_cnt_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_pattern_lock_detector.sv
// Scoreboard bench: two detector instances (defaults, and LOCK=4/UNLOCK=1/CNT=3)
// checked every cycle against a run/miss-counting reference model.
module tb_pattern_lock_detector;

    localparam int W = 3;
    localparam logic [W-1:0] P = 3'b101;
`ifdef PATTERN_MASK_EN
    localparam logic [W-1:0] MASK_FORCE = '0;
`else
    localparam logic [W-1:0] MASK_FORCE = '1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         clear  = 1'b0;
    logic [W-1:0] seq_w  = '0;
    logic [W-1:0] pattern = '0;
    logic [W-1:0] mask   = '1;

    logic       valid0, lost0;
    logic [3:0] mcnt0;
    logic [1:0] state0;
    logic       valid1, lost1;
    logic [2:0] mcnt1;
    logic [1:0] state1;

    pattern_lock_detector u_dut0 (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .clear         (clear),
        .sequence_word (seq_w),
        .pattern       (pattern),
`ifdef PATTERN_MASK_EN
        .mask          (mask),
`endif
        .valid_flag    (valid0),
        .lock_lost     (lost0),
        .match_count   (mcnt0),
        .state         (state0)
    );

    pattern_lock_detector #(
        .SEQUENCE_WIDTH (W),
        .LOCK_COUNT     (4),
        .UNLOCK_COUNT   (1),
        .CNT_WIDTH      (3)
    ) u_dut1 (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .clear         (clear),
        .sequence_word (seq_w),
        .pattern       (pattern),
`ifdef PATTERN_MASK_EN
        .mask          (mask),
`endif
        .valid_flag    (valid1),
        .lock_lost     (lost1),
        .match_count   (mcnt1),
        .state         (state1)
    );

    // Reference model: lengths of the current match run and of the miss run while locked
    typedef struct {
        int run;
        int misses;
        bit locked;
        bit lost;
    } mdl_t;

    typedef struct {
        int state;
        int valid;
        int lost;
        int mcnt;
    } obs_t;

    typedef struct {
        obs_t e0;
        obs_t e1;
    } exp_t;

    mdl_t m0, m1;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit en, bit clr, bit hit,
                                   int lock_n, int unlock_n);
        mdl_t n;
        n = m;
        n.lost = 1'b0;
        if (rst || clr) begin
            n.run = 0; n.misses = 0; n.locked = 1'b0;
        end else if (en) begin
            if (hit) begin
                n.run    = m.run + 1;
                n.misses = 0;
                if (n.run >= lock_n) n.locked = 1'b1;
            end else begin
                n.run = 0;
                if (m.locked) begin
                    n.misses = m.misses + 1;
                    if (n.misses >= unlock_n) begin
                        n.locked = 1'b0;
                        n.misses = 0;
                        n.lost   = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic obs_t expect_of(mdl_t m, int cnt_max);
        obs_t o;
        if (m.locked) o.state = (m.misses > 0) ? 3 : 2;
        else          o.state = (m.run > 0) ? 1 : 0;
        o.valid = m.locked ? 1 : 0;
        o.lost  = m.lost ? 1 : 0;
        o.mcnt  = (m.run > cnt_max) ? cnt_max : m.run;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit rst, input bit en, input bit clr,
                         input logic [W-1:0] s, input logic [W-1:0] p, input logic [W-1:0] mk);
        bit hit;
        @(negedge clk);
        resetn  = ~rst;
        enable  = en;
        clear   = clr;
        seq_w   = s;
        pattern = p;
        mask    = mk | MASK_FORCE;
        hit = (((s ^ p) & mask) == '0);
        m0 = mstep(m0, rst, en, clr, hit, 2, 2);
        m1 = mstep(m1, rst, en, clr, hit, 4, 1);
        q.push_back('{expect_of(m0, 15), expect_of(m1, 7)});
    endtask

    // Monitor: one expected response per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                $display("cyc %0d: st0=%0d v0=%0b ll0=%0b mc0=%0d | st1=%0d v1=%0b ll1=%0b mc1=%0d",
                         cyc, state0, valid0, lost0, mcnt0, state1, valid1, lost1, mcnt1);
                check("dut0.state",       32'(state0), e.e0.state);
                check("dut0.valid_flag",  32'(valid0), e.e0.valid);
                check("dut0.lock_lost",   32'(lost0),  e.e0.lost);
                check("dut0.match_count", 32'(mcnt0),  e.e0.mcnt);
                check("dut1.state",       32'(state1), e.e1.state);
                check("dut1.valid_flag",  32'(valid1), e.e1.valid);
                check("dut1.lock_lost",   32'(lost1),  e.e1.lost);
                check("dut1.match_count", 32'(mcnt1),  e.e1.mcnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rp, rs, rm;
        m0 = '{0, 0, 1'b0, 1'b0};
        m1 = '{0, 0, 1'b0, 1'b0};

        repeat (3)  drive(1, 1, 0, P, P, '1);        // reset defaults
        repeat (2)  drive(0, 1, 0, P, P, '1);        // basic lock
        repeat (20) drive(0, 1, 0, P, P, '1);        // counter saturation
        drive(0, 1, 0, 3'b100, P, '1);               // flywheel and recover
        drive(0, 1, 0, P, P, '1);
        repeat (3)  drive(0, 1, 0, 3'b000, P, '1);   // lock loss
        drive(0, 1, 0, P, P, '1);                    // into VERIFY
        repeat (5)  drive(0, 0, 0, 3'b000, P, '1);   // enable gating
        drive(0, 0, 1, P, P, '1);                    // clear while disabled
        drive(0, 1, 0, P, P, '1);
        drive(0, 1, 1, P, P, '1);                    // clear while enabled
        repeat (5)  drive(0, 1, 0, P, P, '1);
        drive(0, 1, 1, 3'b000, P, '1);               // clear while locked: no lock_lost
        repeat (4)  drive(0, 1, 0, P, P, '1);
        drive(1, 1, 0, P, P, '1);                    // reset mid-lock
        drive(0, 1, 0, P, P, '1);
        repeat (6)  drive(0, 1, 0, 3'b111, P, 3'b101);  // masked compare
        repeat (2)  drive(0, 1, 0, 3'b010, P, 3'b101);

        rp = P;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) rp = W'($urandom());
            rs = ($urandom_range(0, 99) < 70) ? rp : W'($urandom());
            rm = ($urandom_range(0, 3) == 0) ? W'($urandom()) : '1;
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 88,
                  $urandom_range(0, 99) < 3, rs, rp, rm);
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
